// File: rtl/truxton2_video_pkg.sv
// rtl/truxton2_video_pkg.sv - Truxton 2 raster timing constants and VINT state type
package truxton2_video_pkg;

  localparam int unsigned H_TOTAL  = 432;
  localparam int unsigned H_VIS    = 320;
  localparam int unsigned HS_START = 360;
  localparam int unsigned HS_LEN   = 32;
  localparam int unsigned V_TOTAL  = 262;
  localparam int unsigned V_VIS    = 240;
  localparam int unsigned VS_START = 245;
  localparam int unsigned VS_LEN   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } vint_state_e;

endpackage

// File: rtl/truxton2_raster_counter.sv
// rtl/truxton2_raster_counter.sv - enable-gated modulo counter exposing its next value and wrap pulse
module truxton2_raster_counter
  import truxton2_video_pkg::*;
#(
  parameter int unsigned MODULUS = H_TOTAL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [8:0] cnt_q,
  output logic [8:0] cnt_d,
  output logic       wrap
);

  localparam logic [8:0] LAST = 9'(MODULUS - 1);

  // cnt_d and wrap are combinational so the parent can decode from the next value
  always_comb begin
    wrap  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? 9'd0 : cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 9'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truxton2_video_timing.sv
// rtl/truxton2_video_timing.sv - GP9001 raster counters, blank/sync decode and vblank interrupt
module truxton2_video_timing
  import truxton2_video_pkg::*;
#(
  parameter int unsigned H_TOTAL  = truxton2_video_pkg::H_TOTAL,
  parameter int unsigned H_VIS    = truxton2_video_pkg::H_VIS,
  parameter int unsigned HS_START = truxton2_video_pkg::HS_START,
  parameter int unsigned HS_LEN   = truxton2_video_pkg::HS_LEN,
  parameter int unsigned V_TOTAL  = truxton2_video_pkg::V_TOTAL,
  parameter int unsigned V_VIS    = truxton2_video_pkg::V_VIS,
  parameter int unsigned VS_START = truxton2_video_pkg::VS_START,
  parameter int unsigned VS_LEN   = truxton2_video_pkg::VS_LEN
) (
  input  logic       CLK96,
  input  logic       RESET,
  input  logic       CEN675,
  input  logic       IACK,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       VINT
);

  if (H_TOTAL >= 512 || V_TOTAL >= 512 || H_VIS > H_TOTAL || V_VIS >= V_TOTAL) begin : g_bad_range
    $error("truxton2_video_timing: raster parameters out of 9-bit range");
  end
  if (HS_START + HS_LEN > H_TOTAL || VS_START + VS_LEN > V_TOTAL) begin : g_bad_sync
    $error("truxton2_video_timing: sync window wraps past the line/frame end");
  end

  localparam logic [8:0] H_VIS_C    = 9'(H_VIS);
  localparam logic [8:0] HS_START_C = 9'(HS_START);
  localparam logic [8:0] HS_END_C   = 9'(HS_START + HS_LEN);
  localparam logic [8:0] V_VIS_C    = 9'(V_VIS);
  localparam logic [8:0] VS_START_C = 9'(VS_START);
  localparam logic [8:0] VS_END_C   = 9'(VS_START + VS_LEN);

  logic [8:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic       h_wrap, v_wrap;

  truxton2_raster_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
    .clk   (CLK96),
    .rst   (RESET),
    .en    (CEN675),
    .cnt_q (h_cnt_q),
    .cnt_d (h_cnt_d),
    .wrap  (h_wrap)
  );

  truxton2_raster_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
    .clk   (CLK96),
    .rst   (RESET),
    .en    (h_wrap),
    .cnt_q (v_cnt_q),
    .cnt_d (v_cnt_d),
    .wrap  (v_wrap)
  );

  logic hblank_q, hblank_d, vblank_q, vblank_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic vblank_entry;

  // Decoding the next counter value keeps blank/sync aligned with HCNT/VCNT
  always_comb begin
    hblank_d      = (h_cnt_d >= H_VIS_C);
    vblank_d      = (v_cnt_d >= V_VIS_C);
    hsync_d       = (h_cnt_d >= HS_START_C) && (h_cnt_d < HS_END_C);
    vsync_d       = (v_cnt_d >= VS_START_C) && (v_cnt_d < VS_END_C);
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    vblank_entry  = h_wrap && (v_cnt_d == V_VIS_C);
  end

  always_ff @(posedge CLK96) begin
    if (RESET) begin
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  vint_state_e state_q;
  logic        vint_q;

  // A fresh vblank entry outranks a coincident acknowledge
  always_ff @(posedge CLK96) begin
    if (RESET) begin
      state_q <= IDLE;
      vint_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vblank_entry) begin
            state_q <= PEND;
            vint_q  <= 1'b1;
          end
        end
        PEND: begin
          if (IACK && !vblank_entry) begin
            state_q <= IDLE;
            vint_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          vint_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HCNT        = h_cnt_q;
  assign VCNT        = v_cnt_q;
  assign HBLANK      = hblank_q;
  assign VBLANK      = vblank_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign VINT        = vint_q;

endmodule

// File: tb/tb_truxton2_video_timing.sv
// tb/tb_truxton2_video_timing.sv - directed table-driven bench for the raster timing generator
module tb_truxton2_video_timing;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cen = 1'b0;
  logic iack = 1'b0;

  always #5 clk = ~clk;

  logic [8:0] d_hcnt, d_vcnt, s_hcnt, s_vcnt;
  logic d_hblank, d_vblank, d_hsync, d_vsync, d_line_start, d_frame_start, d_vint;
  logic s_hblank, s_vblank, s_hsync, s_vsync, s_line_start, s_frame_start, s_vint;

  // Full-size raster for line-level checks
  truxton2_video_timing dut (
    .CLK96(clk), .RESET(rst), .CEN675(cen), .IACK(iack),
    .HCNT(d_hcnt), .VCNT(d_vcnt), .HBLANK(d_hblank), .VBLANK(d_vblank),
    .HSYNC(d_hsync), .VSYNC(d_vsync), .LINE_START(d_line_start),
    .FRAME_START(d_frame_start), .VINT(d_vint)
  );

  // Shrunken raster (16x12, 192 enables per frame) for frame and interrupt checks
  truxton2_video_timing #(
    .H_TOTAL(16), .H_VIS(10), .HS_START(12), .HS_LEN(2),
    .V_TOTAL(12), .V_VIS(8), .VS_START(9), .VS_LEN(2)
  ) dut_s (
    .CLK96(clk), .RESET(rst), .CEN675(cen), .IACK(iack),
    .HCNT(s_hcnt), .VCNT(s_vcnt), .HBLANK(s_hblank), .VBLANK(s_vblank),
    .HSYNC(s_hsync), .VSYNC(s_vsync), .LINE_START(s_line_start),
    .FRAME_START(s_frame_start), .VINT(s_vint)
  );

  typedef struct {
    int n;
    int h;
    int v;
    int hb;
    int vb;
    int hs;
    int vs;
    int vint;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int en_done = 0;
  int d_hs_en = 0;
  int d_ls = 0;
  int fs_at = -1;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input logic c, input logic a);
    cen  = c;
    iack = a;
    @(posedge clk);
    #1;
    cen  = 1'b0;
    iack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    en_done = 0;
    d_hs_en = 0;
    d_ls    = 0;
    fs_at   = -1;
  endtask

  task automatic run_to(input int target, input int gap);
    while (en_done < target) begin
      tick(1'b1, 1'b0);
      en_done++;
      if (d_hsync) d_hs_en++;
      if (d_line_start) d_ls++;
      if (s_frame_start && fs_at < 0) fs_at = en_done;
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, 1'b0);
        if (d_line_start) d_ls++;
      end
    end
  endtask

  task automatic check_vec(input bit sml, input vec_t t, input string tag);
    chk({tag, " hcnt"},   sml ? int'(s_hcnt)   : int'(d_hcnt),   t.h);
    chk({tag, " vcnt"},   sml ? int'(s_vcnt)   : int'(d_vcnt),   t.v);
    chk({tag, " hblank"}, sml ? int'(s_hblank) : int'(d_hblank), t.hb);
    chk({tag, " vblank"}, sml ? int'(s_vblank) : int'(d_vblank), t.vb);
    chk({tag, " hsync"},  sml ? int'(s_hsync)  : int'(d_hsync),  t.hs);
    chk({tag, " vsync"},  sml ? int'(s_vsync)  : int'(d_vsync),  t.vs);
    chk({tag, " vint"},   sml ? int'(s_vint)   : int'(d_vint),   t.vint);
  endtask

  task automatic check_all_zero(input bit sml, input string tag);
    vec_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_vec(sml, z, tag);
    chk({tag, " line_start"},  sml ? int'(s_line_start)  : int'(d_line_start),  0);
    chk({tag, " frame_start"}, sml ? int'(s_frame_start) : int'(d_frame_start), 0);
  endtask

  vec_t line_tab[8];
  vec_t frame_tab[8];

  initial begin
    //              n    h    v  hb vb hs vs vint
    line_tab[0] = '{1,   1,   0, 0, 0, 0, 0, 0};
    line_tab[1] = '{319, 319, 0, 0, 0, 0, 0, 0};
    line_tab[2] = '{320, 320, 0, 1, 0, 0, 0, 0};
    line_tab[3] = '{359, 359, 0, 1, 0, 0, 0, 0};
    line_tab[4] = '{360, 360, 0, 1, 0, 1, 0, 0};
    line_tab[5] = '{391, 391, 0, 1, 0, 1, 0, 0};
    line_tab[6] = '{392, 392, 0, 1, 0, 0, 0, 0};
    line_tab[7] = '{431, 431, 0, 1, 0, 0, 0, 0};

    frame_tab[0] = '{127, 15, 7,  1, 0, 0, 0, 0};
    frame_tab[1] = '{128, 0,  8,  0, 1, 0, 0, 1};
    frame_tab[2] = '{140, 12, 8,  1, 1, 1, 0, 1};
    frame_tab[3] = '{142, 14, 8,  1, 1, 0, 0, 1};
    frame_tab[4] = '{144, 0,  9,  0, 1, 0, 1, 1};
    frame_tab[5] = '{175, 15, 10, 1, 1, 0, 1, 1};
    frame_tab[6] = '{176, 0,  11, 0, 1, 0, 0, 1};
    frame_tab[7] = '{192, 0,  0,  0, 0, 0, 0, 1};

    // Reset, then idle without enables
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
    check_all_zero(1'b0, "idle");
    check_all_zero(1'b1, "idle_s");

    // One full-size line with CEN675 every 14th cycle
    foreach (line_tab[i]) begin
      run_to(line_tab[i].n, 13);
      check_vec(1'b0, line_tab[i], $sformatf("line[%0d]", line_tab[i].n));
    end
    chk("no strobe before first wrap", d_ls, 0);
    chk("hsync enable count", d_hs_en, 32);
    tick(1'b1, 1'b0);
    en_done++;
    chk("wrap hcnt", int'(d_hcnt), 0);
    chk("wrap vcnt", int'(d_vcnt), 1);
    chk("wrap hblank", int'(d_hblank), 0);
    chk("wrap line_start", int'(d_line_start), 1);
    chk("wrap frame_start", int'(d_frame_start), 0);
    tick(1'b0, 1'b0);
    chk("line_start one cycle", int'(d_line_start), 0);
    chk("hold hcnt", int'(d_hcnt), 0);
    chk("hold vcnt", int'(d_vcnt), 1);

    // Full small frame with CEN675 every cycle
    do_reset();
    foreach (frame_tab[i]) begin
      run_to(frame_tab[i].n, 0);
      check_vec(1'b1, frame_tab[i], $sformatf("frame[%0d]", frame_tab[i].n));
    end
    chk("frame_start enable index", fs_at, 192);
    chk("frame_start at wrap", int'(s_frame_start), 1);
    chk("line_start with frame_start", int'(s_line_start), 1);
    tick(1'b0, 1'b0);
    chk("frame_start one cycle", int'(s_frame_start), 0);

    // Acknowledge after a long wait, then acknowledge while idle
    for (int i = 0; i < 500; i++) tick(1'b0, 1'b0);
    chk("vint held 500 cycles", int'(s_vint), 1);
    tick(1'b0, 1'b1);
    chk("vint cleared by iack", int'(s_vint), 0);
    tick(1'b0, 1'b1);
    chk("iack idle ignored", int'(s_vint), 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    chk("vint stays idle", int'(s_vint), 0);

    // IACK coincident with entry from IDLE
    run_to(319, 0);
    chk("pre-entry vint", int'(s_vint), 0);
    tick(1'b1, 1'b1);
    en_done++;
    chk("entry+iack idle vcnt", int'(s_vcnt), 8);
    chk("entry+iack idle vint", int'(s_vint), 1);

    // IACK coincident with entry while already pending
    run_to(511, 0);
    tick(1'b1, 1'b1);
    en_done++;
    chk("entry+iack pend vcnt", int'(s_vcnt), 8);
    chk("entry+iack pend vint", int'(s_vint), 1);
    run_to(704, 0);
    chk("two frames no iack vint", int'(s_vint), 1);
    chk("two frames vcnt", int'(s_vcnt), 8);
    tick(1'b0, 1'b1);
    chk("single iack clears", int'(s_vint), 0);

    // Mid-frame reset with interrupt pending
    run_to(1013, 0);
    chk("pre-reset hcnt", int'(s_hcnt), 5);
    chk("pre-reset vcnt", int'(s_vcnt), 3);
    chk("pre-reset vint", int'(s_vint), 1);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    rst = 1'b0;
    en_done = 0;
    check_all_zero(1'b1, "rst_s");
    check_all_zero(1'b0, "rst");
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    chk("post-reset hold hcnt", int'(s_hcnt), 0);
    tick(1'b1, 1'b0);
    chk("resume hcnt", int'(s_hcnt), 1);
    chk("resume vcnt", int'(s_vcnt), 0);
    chk("resume line_start", int'(s_line_start), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
